// File: rtl/q_action_engine.sv
// ---------------------------------------------------------------------------
// q_action_engine
//   Q-learning action engine for the tic-tac-toe agent, placed between the
//   per-action Q RAMs and the control unit.
//   SELECT: scans the legal (empty) cells one per cycle and returns the
//           argmax Q. With exploration enabled, it returns an LFSR-chosen
//           legal cell instead.
//   UPDATE: performs a saturating shift-based Q update and pulses a one-hot
//           RAM write enable.
// Ports
//   clock, reset_n          rising-edge clock, async active-low reset
//   start, mode             begin op (IDLE only); 0 = SELECT, 1 = UPDATE
//   q_flat, board           Q(s,a) per action, 2-bit cell codes (00 = empty)
//   explore_en, epsilon     epsilon-greedy control
//   upd_action, q_old,
//   q_next_max, reward      UPDATE operands
//   busy, done              operation in flight / one-cycle result strobe
//   action, q_max, no_move,
//   explored                SELECT results (held until the next done)
//   q_new, en_ram           UPDATE result (held) / write-enable pulse
//   decisions               count of completed SELECTs
// ---------------------------------------------------------------------------
module q_action_engine #(
  parameter int          NUM_ACT  = 9,
  parameter int          QW       = 16,
  parameter int          AW       = 4,
  parameter int          ALPHA_SH = 2,
  parameter int          GAMMA_SH = 1,
  parameter logic [15:0] SEED     = 16'hACE1
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic                  mode,
  input  logic [NUM_ACT*QW-1:0] q_flat,
  input  logic [2*NUM_ACT-1:0]  board,
  input  logic                  explore_en,
  input  logic [7:0]            epsilon,
  input  logic [AW-1:0]         upd_action,
  input  logic [QW-1:0]         q_old,
  input  logic [QW-1:0]         q_next_max,
  input  logic [QW-1:0]         reward,
  output logic                  busy,
  output logic                  done,
  output logic [AW-1:0]         action,
  output logic [QW-1:0]         q_max,
  output logic                  no_move,
  output logic                  explored,
  output logic [QW-1:0]         q_new,
  output logic [NUM_ACT-1:0]    en_ram,
  output logic [15:0]           decisions
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_SCAN = 3'd1,
    S_PICK = 3'd2,
    S_UPD  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  localparam int                     XW      = QW + 3;
  localparam logic [AW-1:0]          LAST_K  = AW'(NUM_ACT - 1);
  localparam logic [AW-1:0]          K_ONE   = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [NUM_ACT-1:0]     ONE_HOT = {{(NUM_ACT-1){1'b0}}, 1'b1};
  localparam logic [NUM_ACT-1:0]     EN_NONE = {NUM_ACT{1'b0}};
  localparam logic signed [XW-1:0]   SAT_HI  = {4'b0000, {(QW-1){1'b1}}};
  localparam logic signed [XW-1:0]   SAT_LO  = {4'b1111, {(QW-1){1'b0}}};

  // Clamp a widened result back into the signed QW range.
  function automatic logic [QW-1:0] saturate(input logic signed [XW-1:0] x);
    logic [QW-1:0] r;
    if (x > SAT_HI) begin
      r = SAT_HI[QW-1:0];
    end else if (x < SAT_LO) begin
      r = SAT_LO[QW-1:0];
    end else begin
      r = x[QW-1:0];
    end
    return r;
  endfunction

  state_t                 state_q, state_d;
  logic [AW-1:0]          k_q, k_d, rnd_q, rnd_d;
  logic                   explore_q, explore_d;
  logic [NUM_ACT*QW-1:0]  q_flat_q, q_flat_d;
  logic [2*NUM_ACT-1:0]   board_q, board_d;
  logic [AW-1:0]          upd_action_q, upd_action_d;
  logic [QW-1:0]          q_old_q, q_old_d, q_next_max_q, q_next_max_d, reward_q, reward_d;
  logic [AW-1:0]          best_idx_q, best_idx_d, fge_idx_q, fge_idx_d, first_idx_q, first_idx_d;
  logic signed [QW-1:0]   best_val_q, best_val_d;
  logic                   best_vld_q, best_vld_d, fge_vld_q, fge_vld_d, first_vld_q, first_vld_d;
  logic [15:0]            lfsr_q, lfsr_d;
  logic                   busy_q, busy_d, done_q, done_d, no_move_q, no_move_d, explored_q, explored_d;
  logic [AW-1:0]          action_q, action_d;
  logic [QW-1:0]          q_max_q, q_max_d, q_new_q, q_new_d;
  logic [NUM_ACT-1:0]     en_ram_q, en_ram_d;
  logic [15:0]            decisions_q, decisions_d;

  logic                   lfsr_fb_s, cell_legal_s;
  logic signed [QW-1:0]   cell_q_s;
  logic [AW-1:0]          pick_idx_s;
  logic [QW-1:0]          pick_q_s;
  logic signed [XW-1:0]   q_old_x_s, q_nm_x_s, rew_x_s, target_s, step_s, sum_s;

  // Fibonacci LFSR, taps 16,14,13,11 in right-shift form.
  assign lfsr_fb_s = lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5];

  // Current scan cell and the cell selected at PICK.
  always_comb begin
    cell_legal_s = (board_q[2*int'(k_q) +: 2] == 2'b00);
    cell_q_s     = q_flat_q[int'(k_q)*QW +: QW];
    // Exploration wraps to the first legal cell when none lies at or above rnd.
    pick_idx_s   = explore_q ? (fge_vld_q ? fge_idx_q : first_idx_q) : best_idx_q;
    pick_q_s     = q_flat_q[int'(pick_idx_s)*QW +: QW];
  end

  // Q update in QW+3 signed bits so the intermediate sums cannot wrap.
  always_comb begin
    q_old_x_s = {{3{q_old_q[QW-1]}}, q_old_q};
    q_nm_x_s  = {{3{q_next_max_q[QW-1]}}, q_next_max_q};
    rew_x_s   = {{3{reward_q[QW-1]}}, reward_q};
    target_s  = rew_x_s + (q_nm_x_s >>> GAMMA_SH);
    step_s    = (target_s - q_old_x_s) >>> ALPHA_SH;
    sum_s     = q_old_x_s + step_s;
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d      = state_q;
    k_d          = k_q;
    rnd_d        = rnd_q;
    explore_d    = explore_q;
    q_flat_d     = q_flat_q;
    board_d      = board_q;
    upd_action_d = upd_action_q;
    q_old_d      = q_old_q;
    q_next_max_d = q_next_max_q;
    reward_d     = reward_q;
    best_idx_d   = best_idx_q;
    best_val_d   = best_val_q;
    best_vld_d   = best_vld_q;
    fge_idx_d    = fge_idx_q;
    fge_vld_d    = fge_vld_q;
    first_idx_d  = first_idx_q;
    first_vld_d  = first_vld_q;
    lfsr_d       = {lfsr_fb_s, lfsr_q[15:1]};
    done_d       = 1'b0;
    en_ram_d     = EN_NONE;
    action_d     = action_q;
    q_max_d      = q_max_q;
    no_move_d    = no_move_q;
    explored_d   = explored_q;
    q_new_d      = q_new_q;
    decisions_d  = decisions_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          q_flat_d     = q_flat;
          board_d      = board;
          upd_action_d = upd_action;
          q_old_d      = q_old;
          q_next_max_d = q_next_max;
          reward_d     = reward;
          explore_d    = explore_en && (lfsr_q[7:0] < epsilon);
          rnd_d        = AW'(lfsr_q[15:8] % NUM_ACT);
          k_d          = {AW{1'b0}};
          best_vld_d   = 1'b0;
          fge_vld_d    = 1'b0;
          first_vld_d  = 1'b0;
          state_d      = mode ? S_UPD : S_SCAN;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SCAN: begin
        if (cell_legal_s) begin
          // Strict > keeps the lowest index on a tie.
          if (!best_vld_q || (cell_q_s > best_val_q)) begin
            best_vld_d = 1'b1;
            best_idx_d = k_q;
            best_val_d = cell_q_s;
          end else begin
            best_vld_d = best_vld_q;
          end
          if (!fge_vld_q && (k_q >= rnd_q)) begin
            fge_vld_d = 1'b1;
            fge_idx_d = k_q;
          end else begin
            fge_vld_d = fge_vld_q;
          end
          if (!first_vld_q) begin
            first_vld_d = 1'b1;
            first_idx_d = k_q;
          end else begin
            first_vld_d = first_vld_q;
          end
        end else begin
          best_vld_d = best_vld_q;
        end
        if (k_q == LAST_K) begin
          state_d = S_PICK;
        end else begin
          k_d = k_q + K_ONE;
        end
      end
      S_PICK: begin
        state_d     = S_DONE;
        done_d      = 1'b1;
        decisions_d = decisions_q + 16'd1;
        if (!first_vld_q) begin
          no_move_d  = 1'b1;
          explored_d = 1'b0;
          action_d   = {AW{1'b0}};
          q_max_d    = {QW{1'b0}};
        end else begin
          no_move_d  = 1'b0;
          explored_d = explore_q;
          action_d   = pick_idx_s;
          q_max_d    = pick_q_s;
        end
      end
      S_UPD: begin
        state_d  = S_DONE;
        done_d   = 1'b1;
        q_new_d  = saturate(sum_s);
        en_ram_d = (int'(upd_action_q) < NUM_ACT) ? (ONE_HOT << upd_action_q) : EN_NONE;
      end
      S_DONE: begin
        // A start seen here is deliberately dropped.
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State, captured operands and registered outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      k_q          <= {AW{1'b0}};
      rnd_q        <= {AW{1'b0}};
      explore_q    <= 1'b0;
      q_flat_q     <= {(NUM_ACT*QW){1'b0}};
      board_q      <= {(2*NUM_ACT){1'b0}};
      upd_action_q <= {AW{1'b0}};
      q_old_q      <= {QW{1'b0}};
      q_next_max_q <= {QW{1'b0}};
      reward_q     <= {QW{1'b0}};
      best_idx_q   <= {AW{1'b0}};
      best_val_q   <= {QW{1'b0}};
      best_vld_q   <= 1'b0;
      fge_idx_q    <= {AW{1'b0}};
      fge_vld_q    <= 1'b0;
      first_idx_q  <= {AW{1'b0}};
      first_vld_q  <= 1'b0;
      lfsr_q       <= SEED;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      action_q     <= {AW{1'b0}};
      q_max_q      <= {QW{1'b0}};
      no_move_q    <= 1'b0;
      explored_q   <= 1'b0;
      q_new_q      <= {QW{1'b0}};
      en_ram_q     <= EN_NONE;
      decisions_q  <= 16'd0;
    end else begin
      state_q      <= state_d;
      k_q          <= k_d;
      rnd_q        <= rnd_d;
      explore_q    <= explore_d;
      q_flat_q     <= q_flat_d;
      board_q      <= board_d;
      upd_action_q <= upd_action_d;
      q_old_q      <= q_old_d;
      q_next_max_q <= q_next_max_d;
      reward_q     <= reward_d;
      best_idx_q   <= best_idx_d;
      best_val_q   <= best_val_d;
      best_vld_q   <= best_vld_d;
      fge_idx_q    <= fge_idx_d;
      fge_vld_q    <= fge_vld_d;
      first_idx_q  <= first_idx_d;
      first_vld_q  <= first_vld_d;
      lfsr_q       <= lfsr_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      action_q     <= action_d;
      q_max_q      <= q_max_d;
      no_move_q    <= no_move_d;
      explored_q   <= explored_d;
      q_new_q      <= q_new_d;
      en_ram_q     <= en_ram_d;
      decisions_q  <= decisions_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign action    = action_q;
  assign q_max     = q_max_q;
  assign no_move   = no_move_q;
  assign explored  = explored_q;
  assign q_new     = q_new_q;
  assign en_ram    = en_ram_q;
  assign decisions = decisions_q;

endmodule

// File: tb/tb_q_action_engine.sv
// Testbench for q_action_engine: a table of directed vectors, hand-written
// multi-cycle sequences, and randomized operations against a reference model.
module tb_q_action_engine;
  localparam int NA = 9;
  localparam int QW = 16;
  localparam int AW = 4;

  logic              clock = 1'b0;
  logic              reset_n = 1'b0;
  logic              start = 1'b0, mode = 1'b0, explore_en = 1'b0;
  logic [NA*QW-1:0]  q_flat = '0;
  logic [2*NA-1:0]   board = '0;
  logic [7:0]        epsilon = 8'd0;
  logic [AW-1:0]     upd_action = '0;
  logic [QW-1:0]     q_old = '0, q_next_max = '0, reward = '0;
  logic              busy, done, no_move, explored;
  logic [AW-1:0]     action;
  logic [QW-1:0]     q_max, q_new;
  logic [NA-1:0]     en_ram;
  logic [15:0]       decisions;

  q_action_engine #(.NUM_ACT(NA), .QW(QW), .AW(AW), .ALPHA_SH(2), .GAMMA_SH(1), .SEED(16'hACE1)) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .mode(mode), .q_flat(q_flat), .board(board),
    .explore_en(explore_en), .epsilon(epsilon), .upd_action(upd_action), .q_old(q_old),
    .q_next_max(q_next_max), .reward(reward), .busy(busy), .done(done), .action(action),
    .q_max(q_max), .no_move(no_move), .explored(explored), .q_new(q_new), .en_ram(en_ram),
    .decisions(decisions));

  always #5 clock = ~clock;

  typedef struct {
    logic             mode;
    logic [NA*QW-1:0] qf;
    logic [2*NA-1:0]  bd;
    logic             xen;
    logic [7:0]       eps;
    logic [AW-1:0]    ua;
    int               qo, qn, rw;
    int               e_action, e_qmax;
    logic             e_nomove, e_expl;
    int               e_qnew;
    logic [NA-1:0]    e_en;
  } vec_t;

  int   checks = 0, failures = 0;
  int   exp_act = 0, exp_qm = 0, exp_qnew = 0, exp_dec = 0;
  logic exp_nm = 1'b0, exp_ex = 1'b0;
  logic [15:0] m_lfsr;

  // LFSR x^16+x^14+x^13+x^11+1, shifting right.
  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    logic b;
    b = v[0] ^ v[2] ^ v[3] ^ v[5];
    return {b, v[15:1]};
  endfunction

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) m_lfsr <= 16'hACE1;
    else          m_lfsr <= lfsr_step(m_lfsr);
  end

  function automatic int qval(input logic [NA*QW-1:0] qf, input int i);
    return int'($signed(qf[i*QW +: QW]));
  endfunction

  function automatic int fdiv(input int x, input int d);
    if (x >= 0) return x / d;
    return -((-x + d - 1) / d);
  endfunction

  function automatic logic [NA*QW-1:0] pack9(input int v0, v1, v2, v3, v4, v5, v6, v7, v8);
    return {QW'(v8), QW'(v7), QW'(v6), QW'(v5), QW'(v4), QW'(v3), QW'(v2), QW'(v1), QW'(v0)};
  endfunction

  function automatic vec_t mk_sel(input logic [NA*QW-1:0] qf, input logic [2*NA-1:0] bd, input logic xen,
                                  input logic [7:0] eps, input int ea, input int eq, input logic enm, input logic eex);
    vec_t v;
    v = '{default: 0};
    v.mode = 1'b0; v.qf = qf; v.bd = bd; v.xen = xen; v.eps = eps;
    v.e_action = ea; v.e_qmax = eq; v.e_nomove = enm; v.e_expl = eex;
    return v;
  endfunction

  function automatic vec_t mk_upd(input int ua, input int qo, input int qn, input int rw,
                                  input int eqn, input logic [NA-1:0] een);
    vec_t v;
    v = '{default: 0};
    v.mode = 1'b1; v.ua = AW'(ua); v.qo = qo; v.qn = qn; v.rw = rw;
    v.e_qnew = eqn; v.e_en = een;
    return v;
  endfunction

  // Reference SELECT: list the legal cells, then pick by argmax or by wrap-around search.
  function automatic void model_select(input vec_t v, input logic [15:0] snap, output vec_t r);
    int  legal[$];
    int  rnd, act;
    logic xpl, found;
    r = v;
    xpl = v.xen && (snap[7:0] < v.eps);
    rnd = int'(snap[15:8]) % NA;
    for (int i = 0; i < NA; i++) if (v.bd[2*i +: 2] == 2'b00) legal.push_back(i);
    if (legal.size() == 0) begin
      r.e_action = 0; r.e_qmax = 0; r.e_nomove = 1'b1; r.e_expl = 1'b0;
    end else begin
      act = legal[0];
      if (xpl) begin
        found = 1'b0;
        for (int j = 0; j < legal.size(); j++)
          if (!found && legal[j] >= rnd) begin act = legal[j]; found = 1'b1; end
      end else begin
        for (int j = 0; j < legal.size(); j++)
          if (qval(v.qf, legal[j]) > qval(v.qf, act)) act = legal[j];
      end
      r.e_action = act; r.e_qmax = qval(v.qf, act); r.e_nomove = 1'b0; r.e_expl = xpl;
    end
  endfunction

  // Reference UPDATE with floor division and clamping in plain integers.
  function automatic void model_update(input vec_t v, output vec_t r);
    int t, q;
    r = v;
    t = v.rw + fdiv(v.qn, 2);
    q = v.qo + fdiv(t - v.qo, 4);
    if (q > 32767) q = 32767;
    if (q < -32768) q = -32768;
    r.e_qnew = q;
    for (int i = 0; i < NA; i++) r.e_en[i] = (int'(v.ua) == i);
  endfunction

  task automatic check(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Drive one operation; returns LFSR seen by the start edge and edges from start edge to done.
  task automatic run_op(input vec_t v, output logic [15:0] snap, output int lat);
    @(negedge clock);
    mode = v.mode; q_flat = v.qf; board = v.bd; explore_en = v.xen; epsilon = v.eps;
    upd_action = v.ua; q_old = QW'(v.qo); q_next_max = QW'(v.qn); reward = QW'(v.rw);
    start = 1'b1;
    snap = m_lfsr;
    @(posedge clock); #1;
    start = 1'b0;
    check("busy_after_start", busy, 1);
    lat = 0;
    while (done !== 1'b1 && lat < 40) begin @(posedge clock); #1; lat++; end
  endtask

  task automatic verify(input vec_t e, input int lat, input string tag);
    logic [NA-1:0] en_exp;
    if (e.mode == 1'b0) begin
      exp_act = e.e_action; exp_qm = e.e_qmax; exp_nm = e.e_nomove; exp_ex = e.e_expl;
      exp_dec = (exp_dec + 1) % 65536;
      en_exp = '0;
    end else begin
      exp_qnew = e.e_qnew;
      en_exp = e.e_en;
    end
    // Counting the start edge as the first, done rises on edge NA+2 (SELECT) or 2 (UPDATE).
    check({tag, " latency"}, lat, e.mode ? 1 : NA + 1);
    check({tag, " done"}, done, 1);
    check({tag, " action"}, action, exp_act);
    check({tag, " q_max"}, $signed(q_max), exp_qm);
    check({tag, " no_move"}, no_move, exp_nm);
    check({tag, " explored"}, explored, exp_ex);
    check({tag, " q_new"}, $signed(q_new), exp_qnew);
    check({tag, " en_ram"}, en_ram, en_exp);
    check({tag, " decisions"}, decisions, exp_dec);
    @(posedge clock); #1;
    check({tag, " done_pulse_end"}, done, 0);
    check({tag, " en_ram_pulse_end"}, en_ram, 0);
    check({tag, " busy_end"}, busy, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[8];
    vec_t v, e;
    logic [15:0] snap;
    int lat, seen;
    logic [NA*QW-1:0] q_t1;

    q_t1 = pack9(12, 10, 13, 17, 18, 32, 62, 8, 1);
    tbl[0] = mk_sel(q_t1, '0, 1'b0, 8'd0, 6, 62, 1'b0, 1'b0);
    tbl[1] = mk_sel(q_t1, 18'b01 << 12, 1'b0, 8'd0, 5, 32, 1'b0, 1'b0);
    tbl[2] = mk_sel(pack9(5, 5, 5, 5, 5, 5, 5, 5, 5), '0, 1'b0, 8'd0, 0, 5, 1'b0, 1'b0);
    tbl[3] = mk_sel(q_t1, {9{2'b10}}, 1'b0, 8'd0, 0, 0, 1'b1, 1'b0);
    tbl[4] = mk_upd(2, 100, 40, 64, 96, 9'b000000100);
    tbl[5] = mk_upd(8, 32767, 32767, 32767, 32767, 9'b100000000);
    tbl[6] = mk_upd(9, -32768, -32768, -32768, -32768, 9'b000000000);
    tbl[7] = mk_sel(q_t1, '0, 1'b1, 8'd0, 6, 62, 1'b0, 1'b0);

    // Reset state.
    repeat (3) @(posedge clock);
    #1;
    check("rst outputs", |{busy, done, action, q_max, no_move, explored, q_new, en_ram, decisions}, 0);
    @(negedge clock);
    reset_n = 1'b1;

    // Directed vectors.
    for (int i = 0; i < 8; i++) begin
      run_op(tbl[i], snap, lat);
      verify(tbl[i], lat, $sformatf("vec%0d", i));
    end

    // Exploration with only cells 2 and 7 legal.
    v = mk_sel(q_t1, {9{2'b01}} & ~((18'b11 << 4) | (18'b11 << 14)), 1'b1, 8'd255, 0, 0, 1'b0, 1'b0);
    run_op(v, snap, lat);
    check("explore legal cell", (action == 4'd2) || (action == 4'd7), 1);
    model_select(v, snap, e);
    verify(e, lat, "explore");

    // Start while busy and start in the DONE cycle are both ignored.
    @(negedge clock);
    mode = 1'b0; q_flat = q_t1; board = '0; explore_en = 1'b0; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    lat = 0;
    while (done !== 1'b1 && lat < 40) begin
      start = (lat == 3);
      mode = (lat == 3);
      @(posedge clock); #1;
      lat++;
    end
    start = 1'b0; mode = 1'b0;
    exp_dec = (exp_dec + 1) % 65536;
    check("busy_start latency", lat, NA + 1);
    check("busy_start action", action, 6);
    check("busy_start q_new", $signed(q_new), exp_qnew);
    check("busy_start decisions", decisions, exp_dec);
    start = 1'b1; mode = 1'b1;
    @(posedge clock); #1;
    check("done_start busy", busy, 0);
    start = 1'b0; mode = 1'b0;
    @(posedge clock); #1;
    check("done_start still idle", busy, 0);
    exp_act = 6; exp_qm = 62; exp_nm = 1'b0; exp_ex = 1'b0;

    // Reset in the middle of a scan.
    @(negedge clock);
    q_flat = q_t1; board = '0; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (4) @(posedge clock);
    #1;
    reset_n = 1'b0;
    #1;
    check("midscan rst outputs", |{busy, done, action, q_max, no_move, explored, q_new, en_ram, decisions}, 0);
    exp_act = 0; exp_qm = 0; exp_nm = 1'b0; exp_ex = 1'b0; exp_qnew = 0; exp_dec = 0;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    seen = 0;
    repeat (15) begin @(posedge clock); #1; if (done === 1'b1) seen = 1; end
    check("midscan no done", seen, 0);
    run_op(tbl[0], snap, lat);
    verify(tbl[0], lat, "after_rst");

    // Randomized operations against the reference model.
    for (int n = 0; n < 60; n++) begin
      v = '{default: 0};
      v.mode = 1'($urandom_range(0, 1));
      for (int i = 0; i < NA; i++) begin
        v.qf[i*QW +: QW] = ($urandom_range(0, 1) == 0) ? QW'($urandom_range(0, 3)) : QW'($urandom);
        v.bd[2*i +: 2] = ($urandom_range(0, 2) == 0) ? 2'b00 : 2'($urandom_range(1, 3));
      end
      v.xen = 1'($urandom_range(0, 1));
      v.eps = 8'($urandom);
      v.ua = AW'($urandom_range(0, 15));
      v.qo = int'($signed(QW'($urandom)));
      v.qn = int'($signed(QW'($urandom)));
      v.rw = ($urandom_range(0, 3) == 0) ? 32767 : int'($signed(QW'($urandom)));
      run_op(v, snap, lat);
      if (v.mode) model_update(v, e);
      else        model_select(v, snap, e);
      verify(e, lat, $sformatf("rnd%0d", n));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
